// File: rtl/bldc_gate_sequencer.sv
// Six-step BLDC gate sequencer: hall sync/decode, dead-time FSM, fault latch.
// Define BLDC_HALL_DEBOUNCE_EN to add the DEBOUNCE stability filter on the hall code.
module bldc_gate_sequencer #(
    parameter int DEAD_TIME = 64,
    parameter int DEBOUNCE  = 16
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic [2:0] hall,
    input  logic       fault_n,
    input  logic       enable,
    input  logic       dir,
    input  logic       pwm_in,
    input  logic       clear_fault,
    output logic [5:0] gate,
    output logic [2:0] sector,
    output logic [1:0] state,
    output logic       hall_error,
    output logic       fault_latched
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DEAD  = 2'd1;
    localparam logic [1:0] S_DRIVE = 2'd2;
    localparam logic [1:0] S_FAULT = 2'd3;
    localparam logic [7:0] DEAD8   = 8'(DEAD_TIME);

    if (DEAD_TIME < 1 || DEAD_TIME > 255 || DEBOUNCE < 1 || DEBOUNCE > 255) begin : g_bad_param
        $error("bldc_gate_sequencer: DEAD_TIME and DEBOUNCE must be in 1..255");
    end

    logic [2:0] hall_s1, hall_s2;
    logic       flt_s1, flt_s2;
    logic       accept;
    logic [2:0] accept_code;
    logic [2:0] sector_d;
    logic       dir_d;
    logic [7:0] dead_cnt;
    logic [1:0] next_state;
    logic       change;
    logic [2:0] ph_hi, ph_lo;
    logic [5:0] gate_next;

    function automatic logic [2:0] decode(input logic [2:0] h);
        case (h)
            3'b101:  decode = 3'd0;
            3'b100:  decode = 3'd1;
            3'b110:  decode = 3'd2;
            3'b010:  decode = 3'd3;
            3'b011:  decode = 3'd4;
            3'b001:  decode = 3'd5;
            default: decode = 3'd7;
        endcase
    endfunction

    // Fault is carried active-high through the synchronizer so a cleared chain means "no fault".
    always_ff @(posedge CLK) begin
        if (reset) begin
            hall_s1 <= '0;
            hall_s2 <= '0;
            flt_s1  <= 1'b0;
            flt_s2  <= 1'b0;
        end else begin
            hall_s1 <= hall;
            hall_s2 <= hall_s1;
            flt_s1  <= ~fault_n;
            flt_s2  <= flt_s1;
        end
    end

`ifdef BLDC_HALL_DEBOUNCE_EN
    localparam logic [7:0] DEB8 = 8'(DEBOUNCE);
    logic [2:0] stab_code;
    logic [7:0] stab_cnt;

    // stab_cnt = consecutive cycles stab_code has been seen, saturating at DEBOUNCE
    always_ff @(posedge CLK) begin
        if (reset) begin
            stab_code <= '0;
            stab_cnt  <= '0;
        end else if (hall_s2 != stab_code) begin
            stab_code <= hall_s2;
            stab_cnt  <= 8'd1;
        end else if (stab_cnt != DEB8) begin
            stab_cnt  <= stab_cnt + 8'd1;
        end
    end

    assign accept      = (stab_cnt == DEB8);
    assign accept_code = stab_code;
`else
    assign accept      = 1'b1;
    assign accept_code = hall_s2;
`endif

    always_ff @(posedge CLK) begin
        if (reset) begin
            sector     <= 3'd7;
            hall_error <= 1'b0;
        end else if (accept) begin
            sector     <= decode(accept_code);
            hall_error <= (accept_code == 3'b000) || (accept_code == 3'b111);
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            sector_d <= 3'd7;
            dir_d    <= 1'b0;
        end else begin
            sector_d <= sector;
            dir_d    <= dir;
        end
    end

    assign change = (sector != sector_d) || (dir != dir_d);

    always_ff @(posedge CLK) begin
        if (reset) state <= S_IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        if (flt_s2) begin
            next_state = S_FAULT;
        end else begin
            case (state)
                S_IDLE:  if (enable && sector != 3'd7) next_state = S_DEAD;
                S_DEAD: begin
                    if (!enable || sector == 3'd7) next_state = S_IDLE;
                    else if (!change && dead_cnt == 8'd1) next_state = S_DRIVE;
                end
                S_DRIVE: begin
                    if (!enable || sector == 3'd7) next_state = S_IDLE;
                    else if (change) next_state = S_DEAD;
                end
                default: if (clear_fault) next_state = S_FAULT == state ? S_IDLE : state;
            endcase
        end
    end

    // Counter is (re)loaded on every entry into DEAD and on any sector/dir change while in it.
    always_ff @(posedge CLK) begin
        if (reset)                                          dead_cnt <= '0;
        else if (next_state == S_DEAD && (state != S_DEAD || change)) dead_cnt <= DEAD8;
        else if (next_state == S_DEAD)                      dead_cnt <= dead_cnt - 8'd1;
        else                                                dead_cnt <= '0;
    end

    // Phase one-hot: bit2 = A, bit1 = B, bit0 = C. Reverse swaps the high and low phase.
    always_comb begin
        ph_hi = 3'b000;
        ph_lo = 3'b000;
        case (sector)
            3'd0: begin ph_hi = 3'b001; ph_lo = 3'b010; end
            3'd1: begin ph_hi = 3'b100; ph_lo = 3'b010; end
            3'd2: begin ph_hi = 3'b100; ph_lo = 3'b001; end
            3'd3: begin ph_hi = 3'b010; ph_lo = 3'b001; end
            3'd4: begin ph_hi = 3'b010; ph_lo = 3'b100; end
            3'd5: begin ph_hi = 3'b001; ph_lo = 3'b100; end
            default: begin ph_hi = 3'b000; ph_lo = 3'b000; end
        endcase
        if (!dir) begin
            {ph_hi, ph_lo} = {ph_lo, ph_hi};
        end
        gate_next = '0;
        if (next_state == S_DRIVE) begin
            gate_next = {ph_hi[2] & pwm_in, ph_lo[2],
                         ph_hi[1] & pwm_in, ph_lo[1],
                         ph_hi[0] & pwm_in, ph_lo[0]};
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) gate <= '0;
        else       gate <= gate_next;
    end

    assign fault_latched = (state == S_FAULT);

endmodule

// File: tb/tb_bldc_gate_sequencer.sv
// Bench for bldc_gate_sequencer: directed scenarios plus random stimulus against a
// cycle-level behavioural model; honours BLDC_HALL_DEBOUNCE_EN like the design.
module tb_bldc_gate_sequencer;
    localparam int DT = 64;
    localparam int DB = 16;
`ifdef BLDC_HALL_DEBOUNCE_EN
    localparam bit DEB_EN = 1'b1;
`else
    localparam bit DEB_EN = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] hall = 3'b000;
    logic       fault_n = 1'b1;
    logic       enable = 1'b0;
    logic       dir = 1'b1;
    logic       pwm_in = 1'b0;
    logic       clear_fault = 1'b0;
    logic [5:0] gate;
    logic [2:0] sector;
    logic [1:0] state;
    logic       hall_error;
    logic       fault_latched;

    always #5 CLK = ~CLK;

    bldc_gate_sequencer #(.DEAD_TIME(DT), .DEBOUNCE(DB)) dut (
        .CLK(CLK), .reset(reset), .hall(hall), .fault_n(fault_n), .enable(enable),
        .dir(dir), .pwm_in(pwm_in), .clear_fault(clear_fault), .gate(gate),
        .sector(sector), .state(state), .hall_error(hall_error), .fault_latched(fault_latched)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: hall code -> sector table and (high, low) phase per sector, A=0 B=1 C=2.
    logic [2:0] dec_tab [8] = '{3'd7, 3'd5, 3'd3, 3'd4, 3'd1, 3'd0, 3'd2, 3'd7};
    int fwd_hi [6] = '{2, 0, 0, 1, 1, 2};
    int fwd_lo [6] = '{1, 1, 2, 2, 0, 0};

    logic [2:0] m_s1, m_s2, m_sector, m_prev_sec;
    logic       m_f1, m_f2, m_herr, m_prev_dir;
    logic [1:0] m_state;
    logic [5:0] m_gate;
    int         m_dead;
    logic [2:0] hist [$];

    task automatic model_step();
        logic [2:0] nsec;
        logic       nherr, chg, stable;
        logic [1:0] nst;
        int         hi, lo, tmp;
        if (reset) begin
            m_s1 = '0; m_s2 = '0; m_f1 = 1'b0; m_f2 = 1'b0; hist.delete();
            m_sector = 3'd7; m_herr = 1'b0; m_state = 2'd0; m_dead = 0;
            m_prev_sec = 3'd7; m_prev_dir = 1'b0; m_gate = '0;
            return;
        end
        nsec = m_sector;
        nherr = m_herr;
        if (!DEB_EN) begin
            nsec = dec_tab[m_s2];
            nherr = (m_s2 == 3'b000) || (m_s2 == 3'b111);
        end else if (hist.size() == DB) begin
            stable = 1'b1;
            foreach (hist[i]) if (hist[i] != hist[0]) stable = 1'b0;
            if (stable) begin
                nsec = dec_tab[hist[0]];
                nherr = (hist[0] == 3'b000) || (hist[0] == 3'b111);
            end
        end
        chg = (m_sector != m_prev_sec) || (dir != m_prev_dir);
        nst = m_state;
        if (m_f2) nst = 2'd3;
        else case (m_state)
            2'd0: if (enable && m_sector != 3'd7) begin nst = 2'd1; m_dead = 1; end
            2'd1: if (!enable || m_sector == 3'd7) nst = 2'd0;
                  else if (chg) m_dead = 1;
                  else if (m_dead == DT) nst = 2'd2;
                  else m_dead++;
            2'd2: if (!enable || m_sector == 3'd7) nst = 2'd0;
                  else if (chg) begin nst = 2'd1; m_dead = 1; end
            default: if (clear_fault) nst = 2'd0;
        endcase
        m_gate = '0;
        if (nst == 2'd2) begin
            hi = fwd_hi[m_sector];
            lo = fwd_lo[m_sector];
            if (!dir) begin tmp = hi; hi = lo; lo = tmp; end
            m_gate[5 - 2 * hi] = pwm_in;
            m_gate[4 - 2 * lo] = 1'b1;
        end
        if (DEB_EN) begin
            hist.push_back(m_s2);
            if (hist.size() > DB) void'(hist.pop_front());
        end
        m_prev_sec = m_sector;
        m_prev_dir = dir;
        m_sector = nsec;
        m_herr = nherr;
        m_state = nst;
        m_s2 = m_s1; m_s1 = hall;
        m_f2 = m_f1; m_f1 = ~fault_n;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
        model_step();
        chk("gate", 16'(gate), 16'(m_gate));
        chk("sector", 16'(sector), 16'(m_sector));
        chk("state", 16'(state), 16'(m_state));
        chk("hall_error", 16'(hall_error), 16'(m_herr));
        chk("fault_latched", 16'(fault_latched), 16'(m_state == 2'd3));
        for (int p = 0; p < 3; p++) chk("shoot_through", 16'(gate[5 - 2 * p] & gate[4 - 2 * p]), 16'd0);
    endtask

    task automatic wait_state(input string tag, input logic [1:0] st, input int budget);
        int n = 0;
        while (state !== st && n < budget) begin cyc(); n++; end
        chk(tag, 16'(state), 16'(st));
    endtask

    task automatic count_dead(input string tag);
        int n = 0;
        while (state === 2'd1 && n < 1000) begin n++; cyc(); end
        chk(tag, 16'(n), 16'(DT));
    endtask

    int hold;

    initial begin
        // Reset state
        repeat (3) cyc();
        chk("rst_gate", 16'(gate), 16'd0);
        chk("rst_sector", 16'(sector), 16'd7);
        chk("rst_state", 16'(state), 16'd0);
        chk("rst_herr", 16'(hall_error), 16'd0);
        chk("rst_fault", 16'(fault_latched), 16'd0);

        // Start-up in sector 0, forward, pwm high
        reset = 1'b0; hall = 3'b101; enable = 1'b1; dir = 1'b1; pwm_in = 1'b1;
        wait_state("s0_to_dead", 2'd1, 100);
        count_dead("s0_dead_len");
        chk("s0_drive", 16'(state), 16'd2);
        chk("s0_gate", 16'(gate), 16'(6'b000110));
        chk("s0_sector", 16'(sector), 16'd0);
        repeat (30) begin pwm_in = 1'($urandom); cyc(); end

        // Commutate to sector 1
        pwm_in = 1'b1; hall = 3'b100;
        wait_state("s1_to_dead", 2'd1, 60);
        count_dead("s1_dead_len");
        chk("s1_gate", 16'(gate), 16'(6'b100100));

        // Short glitch towards sector 2
        hall = 3'b110;
        repeat (5) begin
            cyc();
`ifdef BLDC_HALL_DEBOUNCE_EN
            chk("glitch_sector", 16'(sector), 16'd1);
            chk("glitch_gate", 16'(gate), 16'(6'b100100));
`endif
        end
        hall = 3'b100;
        wait_state("glitch_recover", 2'd2, 300);
        repeat (10) begin pwm_in = 1'($urandom); cyc(); end

        // Sector 2 forward, then reverse
        pwm_in = 1'b1; hall = 3'b110;
        wait_state("s2_to_dead", 2'd1, 60);
        count_dead("s2_dead_len");
        chk("s2_fwd_gate", 16'(gate), 16'(6'b100001));
        dir = 1'b0;
        wait_state("dir_to_dead", 2'd1, 10);
        count_dead("dir_dead_len");
        chk("s2_rev_gate", 16'(gate), 16'(6'b010010));

        // Invalid hall code
        hall = 3'b111;
        wait_state("invalid_idle", 2'd0, 60);
        chk("invalid_sector", 16'(sector), 16'd7);
        chk("invalid_herr", 16'(hall_error), 16'd1);
        chk("invalid_gate", 16'(gate), 16'd0);

        // Fault, ignored clear, then proper clear
        hall = 3'b101; dir = 1'b1;
        wait_state("pre_fault_drive", 2'd2, 300);
        fault_n = 1'b0; cyc(); fault_n = 1'b1;
        wait_state("fault_entry", 2'd3, 10);
        chk("fault_gate", 16'(gate), 16'd0);
        chk("fault_flag", 16'(fault_latched), 16'd1);
        fault_n = 1'b0; repeat (3) cyc();
        clear_fault = 1'b1; cyc(); clear_fault = 1'b0;
        fault_n = 1'b1; repeat (3) cyc();
        chk("clear_ignored", 16'(state), 16'd3);
        clear_fault = 1'b1; cyc(); clear_fault = 1'b0;
        chk("clear_idle", 16'(state), 16'd0);
        cyc();
        chk("clear_dead", 16'(state), 16'd1);
        count_dead("clear_dead_len");
        chk("clear_drive", 16'(state), 16'd2);

        // Random operation
        hold = 0;
        for (int i = 0; i < 3000; i++) begin
            if (hold == 0) begin
                hall = 3'($urandom_range(0, 7));
                hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : int'($urandom_range(20, 150));
            end
            hold--;
            pwm_in = 1'($urandom);
            if ($urandom_range(0, 399) == 0) dir = ~dir;
            enable = ($urandom_range(0, 99) != 0);
            fault_n = ($urandom_range(0, 299) != 0);
            clear_fault = ($urandom_range(0, 19) == 0);
            cyc();
        end

        // Reset while driving
        hall = 3'b101; enable = 1'b1; fault_n = 1'b1; clear_fault = 1'b0; dir = 1'b1; pwm_in = 1'b1;
        repeat (3) cyc();
        clear_fault = 1'b1; cyc(); clear_fault = 1'b0;
        wait_state("pre_reset_drive", 2'd2, 400);
        reset = 1'b1; cyc();
        chk("midrst_gate", 16'(gate), 16'd0);
        chk("midrst_state", 16'(state), 16'd0);
        chk("midrst_sector", 16'(sector), 16'd7);
        reset = 1'b0; cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
